// File: rtl/rx_frame_parser_pkg.sv
// rx_frame_parser_pkg: shared types and constants for the rx frame parser.
// The CRC state exists only when RX_FRAME_CRC_EN is defined.
package rx_frame_parser_pkg;

  localparam int unsigned MAX_LEN_DEF = 255;
  localparam int unsigned TIMEOUT_DEF = 4096;
  localparam logic [7:0]  CRC_POLY    = 8'h07;

`ifdef RX_FRAME_CRC_EN
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CRC,
    DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DONE
  } state_t;
`endif

  // CRC-8, MSB first, no reflection, no final xor
  function automatic logic [7:0] crc8_byte(
    input logic [7:0] crc,
    input logic [7:0] d
  );
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_frame_parser_if.sv
// rx_frame_parser_if: symbol input and frame output bundle.
// master drives symbols/sync, slave is the parser.
interface rx_frame_parser_if;

  logic       sym_valid;
  logic [1:0] sym_data;
  logic       BPSK;
  logic       BD_flag;
  logic       BD_sgn;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_done;
  logic       crc_ok;
  logic       frame_err;
  logic       disassert_PD;
  logic       disassert_BD;

  modport master (
    output sym_valid,
    output sym_data,
    output BPSK,
    output BD_flag,
    output BD_sgn,
    input  byte_data,
    input  byte_valid,
    input  frame_done,
    input  crc_ok,
    input  frame_err,
    input  disassert_PD,
    input  disassert_BD
  );

  modport slave (
    input  sym_valid,
    input  sym_data,
    input  BPSK,
    input  BD_flag,
    input  BD_sgn,
    output byte_data,
    output byte_valid,
    output frame_done,
    output crc_ok,
    output frame_err,
    output disassert_PD,
    output disassert_BD
  );

endinterface

// File: rtl/rx_crc8.sv
// rx_crc8: running CRC-8 register, one byte per enable.
// Poly 0x07, init 0x00, MSB first.
module rx_crc8
  import rx_frame_parser_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc8_byte(crc, data_in);
    end
  end

endmodule

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: decided symbols -> length, payload bytes, CRC-8.
// Define RX_FRAME_CRC_EN to check the trailing CRC byte.
module rx_frame_parser
  import rx_frame_parser_pkg::*;
#(
  parameter int unsigned MAX_LEN     = MAX_LEN_DEF,
  parameter int unsigned TIMEOUT_SYM = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst_32M768,
  rx_frame_parser_if.slave rx
);

  localparam int CW = $clog2(TIMEOUT_SYM + 1);
  localparam logic [7:0]    MAX_L  = 8'(MAX_LEN);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_SYM);

  state_t state_q, state_d;

  logic          bd_q;
  logic          sgn_q, sgn_d;
  logic          bpsk_q, bpsk_d;
  logic [7:0]    sh_q, sh_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    pcnt_q, pcnt_d;
  logic [CW-1:0] scnt_q, scnt_d;

  logic [7:0] bdata_q, bdata_d;
  logic       bvalid_q, bvalid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       ok_q, ok_d;

  logic          bd_rise;
  logic          in_frame;
  logic          sym_in;
  logic          d1, d0;
  logic [7:0]    shifted;
  logic [3:0]    bcnt_inc;
  logic [CW-1:0] scnt_nx;
  logic          byte_rdy;
  logic          timeout;
  logic          fin, fail, ok_val;

  assign bd_rise  = rx.BD_flag & ~bd_q;
  assign in_frame = (state_q != IDLE) && (state_q != DONE);
  assign sym_in   = in_frame & rx.sym_valid;

  // Polarity from the sync word applies to every bit of the frame
  assign d1 = rx.sym_data[1] ^ sgn_q;
  assign d0 = rx.sym_data[0] ^ sgn_q;

  assign shifted  = bpsk_q ? {sh_q[6:0], d0}
                           : {sh_q[5:0], d1, d0};
  assign bcnt_inc = bcnt_q + (bpsk_q ? 4'd1 : 4'd2);
  assign scnt_nx  = scnt_q + CW'(1);
  assign byte_rdy = sym_in && (bcnt_inc == 4'd8);
  assign timeout  = sym_in && (scnt_nx == TO_CNT);

`ifdef RX_FRAME_CRC_EN
  logic       crc_clr;
  logic       crc_en;
  logic [7:0] crc_val;

  rx_crc8 u_crc (
    .clk     (clk),
    .rst     (rst_32M768),
    .clear   (crc_clr),
    .enable  (crc_en),
    .data_in (shifted),
    .crc     (crc_val)
  );
`endif

  always_comb begin
    state_d  = state_q;
    sgn_d    = sgn_q;
    bpsk_d   = bpsk_q;
    sh_d     = sh_q;
    bcnt_d   = bcnt_q;
    len_d    = len_q;
    pcnt_d   = pcnt_q;
    scnt_d   = scnt_q;
    bdata_d  = bdata_q;
    bvalid_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ok_d     = ok_q;
    fin      = 1'b0;
    fail     = 1'b0;
`ifdef RX_FRAME_CRC_EN
    ok_val   = 1'b0;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
`else
    ok_val   = 1'b1;
`endif

    if (sym_in) begin
      sh_d   = shifted;
      bcnt_d = byte_rdy ? 4'd0 : bcnt_inc;
      scnt_d = scnt_nx;
    end

    unique case (state_q)
      IDLE: begin
        if (bd_rise) begin
          state_d = HDR;
          sgn_d   = rx.BD_sgn;
          bpsk_d  = rx.BPSK;
          sh_d    = '0;
          bcnt_d  = '0;
          pcnt_d  = '0;
          scnt_d  = '0;
`ifdef RX_FRAME_CRC_EN
          crc_clr = 1'b1;
`endif
        end
      end
      HDR: begin
        if (byte_rdy) begin
          len_d = shifted;
`ifdef RX_FRAME_CRC_EN
          crc_en = 1'b1;
`endif
          if (shifted == 8'd0) begin
`ifdef RX_FRAME_CRC_EN
            state_d = CRC;
`else
            fin = 1'b1;
`endif
          end else if (shifted > MAX_L) begin
            fin  = 1'b1;
            fail = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_rdy) begin
          bvalid_d = 1'b1;
          bdata_d  = shifted;
          pcnt_d   = pcnt_q + 8'd1;
`ifdef RX_FRAME_CRC_EN
          crc_en   = 1'b1;
          if (pcnt_d == len_q) state_d = CRC;
`else
          if (pcnt_d == len_q) fin = 1'b1;
`endif
        end
      end
`ifdef RX_FRAME_CRC_EN
      CRC: begin
        if (byte_rdy) begin
          fin    = 1'b1;
          ok_val = (shifted == crc_val);
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A stalled frame wins over a byte completing on the same strobe
    if (timeout) begin
      fin      = 1'b1;
      fail     = 1'b1;
      bvalid_d = 1'b0;
    end

    if (fin) begin
      state_d = DONE;
      done_d  = 1'b1;
      err_d   = fail;
      ok_d    = ok_val & ~fail;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_32M768) begin
      state_q  <= IDLE;
      bd_q     <= 1'b0;
      sgn_q    <= 1'b0;
      bpsk_q   <= 1'b0;
      sh_q     <= '0;
      bcnt_q   <= '0;
      len_q    <= '0;
      pcnt_q   <= '0;
      scnt_q   <= '0;
      bdata_q  <= '0;
      bvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bd_q     <= rx.BD_flag;
      sgn_q    <= sgn_d;
      bpsk_q   <= bpsk_d;
      sh_q     <= sh_d;
      bcnt_q   <= bcnt_d;
      len_q    <= len_d;
      pcnt_q   <= pcnt_d;
      scnt_q   <= scnt_d;
      bdata_q  <= bdata_d;
      bvalid_q <= bvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ok_q     <= ok_d;
    end
  end

  assign rx.byte_data    = bdata_q;
  assign rx.byte_valid   = bvalid_q;
  assign rx.frame_done   = done_q;
  assign rx.crc_ok       = ok_q;
  assign rx.frame_err    = err_q;
  assign rx.disassert_PD = done_q;
  assign rx.disassert_BD = done_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// tb_rx_frame_parser: directed frames against rx_frame_parser.
// Honors RX_FRAME_CRC_EN for the expected crc_ok of a bad CRC byte.
module tb_rx_frame_parser;

`ifdef RX_FRAME_CRC_EN
  localparam logic BAD_OK = 1'b0;
`else
  localparam logic BAD_OK = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_frame_parser_if ifa ();
  rx_frame_parser_if ifb ();

  assign ifb.sym_valid = ifa.sym_valid;
  assign ifb.sym_data  = ifa.sym_data;
  assign ifb.BPSK      = ifa.BPSK;
  assign ifb.BD_flag   = ifa.BD_flag;
  assign ifb.BD_sgn    = ifa.BD_sgn;

  rx_frame_parser #(
    .MAX_LEN     (4),
    .TIMEOUT_SYM (64)
  ) u_dut (
    .clk        (clk),
    .rst_32M768 (rst),
    .rx         (ifa)
  );

  rx_frame_parser #(
    .TIMEOUT_SYM (64)
  ) u_big (
    .clk        (clk),
    .rst_32M768 (rst),
    .rx         (ifb)
  );

  int checks = 0;
  int errors = 0;
  int nb, nd, nerr, npd, nbd, nerr_b, nd_b;
  logic [7:0] bytes [8];
  logic last_ok, last_err;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.byte_valid) begin
        bytes[nb[2:0]] = ifa.byte_data;
        nb++;
      end
      if (ifa.frame_done) begin
        nd++;
        last_ok  = ifa.crc_ok;
        last_err = ifa.frame_err;
      end
      if (ifa.frame_err) nerr++;
      if (ifa.disassert_PD) npd++;
      if (ifa.disassert_BD) nbd++;
      if (ifb.frame_err) nerr_b++;
      if (ifb.frame_done) nd_b++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic clr();
    nb = 0; nd = 0; nerr = 0; npd = 0; nbd = 0;
    nerr_b = 0; nd_b = 0;
    last_ok = 1'bx; last_err = 1'bx;
    for (int i = 0; i < 8; i++) bytes[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifa.sym_valid = 1'b0;
    ifa.BD_flag = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_sym(input logic [1:0] d);
    @(negedge clk);
    ifa.sym_valid = 1'b1;
    ifa.sym_data = d;
    @(negedge clk);
    ifa.sym_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic q,
                           input logic inv);
    logic [7:0] t;
    t = inv ? ~b : b;
    if (q) begin
      for (int i = 3; i >= 0; i--) send_sym({t[2*i+1], t[2*i]});
    end else begin
      for (int i = 7; i >= 0; i--) send_sym({1'b0, t[i]});
    end
  endtask

  task automatic start(input logic sgn, input logic bp,
                       input logic junk);
    @(negedge clk);
    ifa.BD_sgn = sgn;
    ifa.BPSK = bp;
    ifa.BD_flag = 1'b1;
    if (junk) begin
      ifa.sym_valid = 1'b1;
      ifa.sym_data = 2'b11;
    end
    @(negedge clk);
    ifa.sym_valid = 1'b0;
    ifa.BD_flag = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.byte_data, ifa.byte_valid, ifa.frame_done, ifa.crc_ok,
         ifa.frame_err, ifa.disassert_PD, ifa.disassert_BD} !== 14'd0) begin
      errors++;
      $display("FAIL reset_a: got %0h exp 0", {ifa.byte_data,
        ifa.byte_valid, ifa.frame_done, ifa.crc_ok, ifa.frame_err,
        ifa.disassert_PD, ifa.disassert_BD});
    end
    checks++;
    if ({ifb.byte_valid, ifb.frame_done, ifb.frame_err} !== 3'd0) begin
      errors++;
      $display("FAIL reset_b: got %0h exp 0",
        {ifb.byte_valid, ifb.frame_done, ifb.frame_err});
    end
    rst = 1'b0;
  endtask

  task automatic test_bpsk();
    clr();
    start(1'b0, 1'b1, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    #1;
    checks++;
    if ({ifa.byte_valid, ifa.byte_data} !== 9'h1A5) begin
      errors++;
      $display("FAIL bpsk_latency: got %0h exp 1a5",
        {ifa.byte_valid, ifa.byte_data});
    end
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'h3B, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({nb, bytes[0], bytes[1]} !== {32'd2, 8'hA5, 8'h3C}) begin
      errors++;
      $display("FAIL bpsk_bytes: got n=%0d %0h %0h exp n=2 a5 3c",
        nb, bytes[0], bytes[1]);
    end
    checks++;
    if ({nd, last_ok, last_err} !== {32'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL bpsk_done: got n=%0d ok=%0b err=%0b exp 1 1 0",
        nd, last_ok, last_err);
    end
    checks++;
    if ({npd, nbd} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL bpsk_disassert: got pd=%0d bd=%0d exp 1 1",
        npd, nbd);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ifa.crc_ok !== 1'b1) begin
      errors++;
      $display("FAIL crc_ok_hold: got %0b exp 1", ifa.crc_ok);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    start(1'b0, 1'b1, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    #1;
    checks++;
    if ({nb, bytes[2]} !== {32'd3, 8'h33}) begin
      errors++;
      $display("FAIL mid_bytes: got n=%0d %0h exp n=3 33", nb, bytes[2]);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ifa.byte_data, ifa.byte_valid, ifa.frame_done, ifa.crc_ok,
         ifa.frame_err, ifa.disassert_PD, ifa.disassert_BD} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset_out: got %0h exp 0", {ifa.byte_data,
        ifa.byte_valid, ifa.frame_done, ifa.crc_ok, ifa.frame_err,
        ifa.disassert_PD, ifa.disassert_BD});
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if ({nb, nd, npd} !== {32'd3, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL mid_no_pulse: got b=%0d d=%0d pd=%0d exp 3 0 0",
        nb, nd, npd);
    end
    clr();
    start(1'b0, 1'b1, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'h3B, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({nb, bytes[0], bytes[1]} !== {32'd2, 8'hA5, 8'h3C}) begin
      errors++;
      $display("FAIL after_rst_bytes: got n=%0d %0h %0h exp n=2 a5 3c",
        nb, bytes[0], bytes[1]);
    end
    checks++;
    if ({nd, last_ok, last_err} !== {32'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL after_rst_done: got n=%0d ok=%0b err=%0b exp 1 1 0",
        nd, last_ok, last_err);
    end
  endtask

  task automatic test_qpsk_inv();
    clr();
    start(1'b1, 1'b0, 1'b1);
    send_byte(8'h02, 1'b1, 1'b1);
    ifa.BPSK = 1'b1;
    send_byte(8'hA5, 1'b1, 1'b1);
    send_byte(8'h3C, 1'b1, 1'b1);
    send_byte(8'h3B, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({nb, bytes[0], bytes[1]} !== {32'd2, 8'hA5, 8'h3C}) begin
      errors++;
      $display("FAIL qpsk_bytes: got n=%0d %0h %0h exp n=2 a5 3c",
        nb, bytes[0], bytes[1]);
    end
    checks++;
    if ({nd, last_ok, last_err} !== {32'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL qpsk_done: got n=%0d ok=%0b err=%0b exp 1 1 0",
        nd, last_ok, last_err);
    end
  endtask

  task automatic test_crc_bad();
    clr();
    start(1'b0, 1'b1, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'h3A, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({nb, bytes[0], bytes[1]} !== {32'd2, 8'hA5, 8'h3C}) begin
      errors++;
      $display("FAIL badcrc_bytes: got n=%0d %0h %0h exp n=2 a5 3c",
        nb, bytes[0], bytes[1]);
    end
    checks++;
    if ({nd, last_ok, last_err} !== {32'd1, BAD_OK, 1'b0}) begin
      errors++;
      $display("FAIL badcrc_done: got n=%0d ok=%0b err=%0b exp 1 %0b 0",
        nd, last_ok, last_err, BAD_OK);
    end
  endtask

  task automatic test_len();
    clr();
    start(1'b0, 1'b1, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    #1;
    checks++;
    if ({nd, last_err, last_ok} !== {32'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL len_done: got n=%0d err=%0b ok=%0b exp 1 1 0",
        nd, last_err, last_ok);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if ({nb, nerr, npd} !== {32'd0, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL len_pulses: got b=%0d e=%0d pd=%0d exp 0 1 1",
        nb, nerr, npd);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    clr();
    start(1'b0, 1'b1, 1'b0);
    send_byte(8'h10, 1'b0, 1'b0);
    @(negedge clk);
    ifa.BD_flag = 1'b1;
    @(negedge clk);
    ifa.BD_flag = 1'b0;
    for (int i = 0; i < 55; i++) send_sym(2'b00);
    #1;
    checks++;
    if ({nerr_b, nd_b} !== {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL timeout_early: got e=%0d d=%0d exp 0 0",
        nerr_b, nd_b);
    end
    send_sym(2'b00);
    #1;
    checks++;
    if ({nerr_b, nd_b} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL timeout_64: got e=%0d d=%0d exp 1 1",
        nerr_b, nd_b);
    end
    checks++;
    if (ifb.crc_ok !== 1'b0) begin
      errors++;
      $display("FAIL timeout_crc_ok: got %0b exp 0", ifb.crc_ok);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifa.sym_valid = 1'b0;
    ifa.sym_data = 2'b00;
    ifa.BPSK = 1'b1;
    ifa.BD_flag = 1'b0;
    ifa.BD_sgn = 1'b0;
    clr();
    test_reset();
    test_bpsk();
    test_reset_mid();
    test_qpsk_inv();
    test_crc_bad();
    test_len();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_parser.md
RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 255, giving the maximum accepted payload length in bytes (1..255).
REQ-002 SHALL have parameter TIMEOUT_SYM, default 4096, giving the symbol-strobe count without frame completion before abort.
REQ-003 clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 rst_32M768  in  1  synchronous, active-high reset.
REQ-005 sym_valid  in  1  one-cycle strobe marking one decided symbol.
REQ-006 sym_data  in  2  decided symbol bits; BPSK uses [0] only; QPSK sends [1] first, then [0].
REQ-007 BPSK  in  1  1 = BPSK (1 bit/symbol), 0 = QPSK (2 bits/symbol).
REQ-008 BD_flag  in  1  Barker/sync detected; level input, rising edge is significant.
REQ-009 BD_sgn  in  1  detected sync polarity; 1 = all following bits inverted.
REQ-010 byte_data  out  8  assembled payload byte.
REQ-011 byte_valid  out  1  one-cycle strobe qualifying byte_data.
REQ-012 frame_done  out  1  one-cycle strobe at frame end (good or bad).
REQ-013 crc_ok  out  1  result of the CRC check; valid while frame_done=1.
REQ-014 frame_err  out  1  one-cycle strobe on length violation or timeout.
REQ-015 disassert_PD  out  1  one-cycle pulse that re-arms preamble detection.
REQ-016 disassert_BD  out  1  one-cycle pulse that re-arms Barker detection.

Function
REQ-017 SHALL implement states IDLE, HDR, PAYLOAD, CRC, DONE.
REQ-018 IDLE -> HDR on a BD_flag rising edge (registered compare); this transition latches BD_sgn and BPSK for the whole frame.
REQ-019 Every received bit SHALL be XORed with the latched BD_sgn; bits are shifted in MSB first.
REQ-020 A byte completes after 8 bits: 8 symbols in BPSK, 4 in QPSK. A QPSK symbol SHALL NOT be split across bytes.
REQ-021 HDR: the first byte is the length L; it is not output on byte_data.
  - L = 0 -> CRC (or DONE without CRC).
  - L > MAX_LEN -> DONE with frame_err=1.
  - Otherwise -> PAYLOAD.
REQ-022 PAYLOAD: each completed byte SHALL drive byte_valid=1 for exactly one cycle, the cycle after the completing sym_valid (latency 1). After L bytes -> CRC.
REQ-023 CRC: receive one byte, compare it to the running CRC-8 (poly 0x07, init 0x00, MSB first, computed over L and the payload), then -> DONE.
REQ-024 DONE lasts exactly one cycle.
  - frame_done=1, and disassert_PD = disassert_BD = 1, in that cycle.
  - crc_ok holds its value until the next frame_done.
  - Next state is IDLE.
REQ-025 A symbol counter SHALL reset on entry to HDR and increment on each sym_valid. Reaching TIMEOUT_SYM in any non-IDLE state -> DONE with frame_err=1 and crc_ok=0.
REQ-026 BD_flag edges outside IDLE SHALL be ignored; sym_valid in IDLE SHALL be ignored.
REQ-027 If a BD_flag edge and sym_valid arrive in the same cycle in IDLE, that symbol SHALL NOT be counted as frame data.
REQ-028 Changes of the BPSK input mid-frame SHALL have no effect.

Reset
REQ-029 While reset is active, the block SHALL be in state IDLE with every output, counter, shift register and CRC register at 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no frame_done, byte_valid or disassert pulse.

Configuration
REQ-031 With RX_FRAME_CRC_EN defined: the CRC state and CRC-8 logic SHALL be present, and crc_ok reflects the comparison.
REQ-032 With RX_FRAME_CRC_EN undefined: the CRC state SHALL be omitted and PAYLOAD (or HDR when L=0) goes directly to DONE; crc_ok SHALL be 1 at frame_done except when frame_err=1.

Structure
REQ-033 The state enum, CRC polynomial 0x07 and default MAX_LEN/TIMEOUT_SYM SHALL live in the shared rx package.
REQ-034 The CRC-8 byte update SHALL be a sub-module, rx_crc8, with inputs clear, enable and data_in[7:0], and output crc[7:0].

Verification
REQ-035 BPSK, BD_sgn=0, bytes 0x02, 0xA5, 0x3C, then a correct CRC -> two byte_valid pulses (0xA5, 0x3C), then frame_done with crc_ok=1 and disassert pulses.
REQ-036 Same frame in QPSK with BD_sgn=1 and every transmitted bit inverted -> identical bytes 0xA5, 0x3C; crc_ok=1.
REQ-037 Same frame with the CRC byte corrupted by XOR 0x01 -> bytes still output; frame_done with crc_ok=0.
REQ-038 MAX_LEN=4 with header 0x05 -> no byte_valid; frame_done=1, frame_err=1 within 1 cycle of the header byte completing.
REQ-039 Header 0x10 followed by sym_valid stopping, TIMEOUT_SYM=64 -> frame_err at symbol count 64; a second BD_flag edge during the frame is ignored.
REQ-040 Reset pulsed after 3 payload bytes -> outputs 0 and IDLE; a following good frame decodes correctly.
